// File: rtl/k423_pkg.sv
// Shared definitions for the k423 instruction-fetch slice.
package k423_pkg;

  localparam logic [31:0] K423_RST_PC = 32'h8000_0000;
  localparam int unsigned K423_MAX_OS = 2;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_FETCH,
    FS_HOLD
  } fetch_state_e;

  // Ordered so that a numerically larger value wins arbitration.
  typedef enum logic [1:0] {
    RP_NONE,
    RP_BPU,
    RP_BJU,
    RP_TRAP
  } redir_prio_e;

endpackage

// File: rtl/utils_adder32.sv
// 32-bit adder, carry out dropped (wraps modulo 2^32).
module utils_adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/utils_fifo.sv
// Small synchronous FIFO with flush; head visible combinationally on pop_data_o.
module utils_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             full, empty, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && !flush_i) assert (!(push_i && full));
  end

  assign pop_data_o = mem[rd_ptr];
  assign count_o    = cnt;

endmodule

// File: rtl/k423_if_fetch_ctrl.sv
// Instruction fetch controller: redirect arbitration, credit-limited bus
// issue, stale-response killing and instruction buffering.
module k423_if_fetch_ctrl
  import k423_pkg::*;
#(
  parameter logic [31:0] RST_PC = K423_RST_PC,
  parameter int unsigned MAX_OS = K423_MAX_OS
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        trap_redir_i,
  input  logic [31:0] trap_pc_i,
  input  logic        bju_redir_i,
  input  logic [31:0] bju_pc_i,
  input  logic        bpu_redir_i,
  input  logic [31:0] bpu_pc_i,
  input  logic        stall_i,
  output logic        ibus_req_vld_o,
  output logic [31:0] ibus_req_addr_o,
  input  logic        ibus_req_rdy_i,
  input  logic        ibus_rsp_vld_i,
  input  logic [31:0] ibus_rsp_data_i,
  output logic        inst_vld_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        if_rdy_i
);

  localparam int unsigned BCW   = $clog2(MAX_OS + 1);
  localparam int unsigned CNT_W = BCW + 3;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d, pc_plus4, pc_head;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d, kill_cnt_q, kill_cnt_d, in_use;
  logic             rbuf_vld_q, rbuf_vld_d;
  redir_prio_e      rbuf_prio_q, rbuf_prio_d, new_prio, merged_prio;
  logic [31:0]      rbuf_pc_q, rbuf_pc_d, new_pc, merged_pc;
  logic             redir, take_new, merged_vld, credit, req_vld, hs;
  logic             rsp_live, pc_push, inst_pop;
  logic [BCW-1:0]   pc_cnt, ibuf_cnt;
  logic [63:0]      ibuf_head;

  always_comb begin
    new_prio = RP_NONE;
    new_pc   = '0;
    if (trap_redir_i) begin
      new_prio = RP_TRAP;
      new_pc   = trap_pc_i;
    end else if (bju_redir_i) begin
      new_prio = RP_BJU;
      new_pc   = bju_pc_i;
    end else if (bpu_redir_i) begin
      new_prio = RP_BPU;
      new_pc   = bpu_pc_i;
    end
  end

  // A newer redirect replaces a buffered one unless it is of lower priority.
  assign redir       = (new_prio != RP_NONE);
  assign take_new    = redir && (!rbuf_vld_q || (new_prio >= rbuf_prio_q));
  assign merged_vld  = redir || rbuf_vld_q;
  assign merged_pc   = take_new ? new_pc : rbuf_pc_q;
  assign merged_prio = take_new ? new_prio : rbuf_prio_q;

  assign in_use = os_cnt_q - kill_cnt_q + CNT_W'(ibuf_cnt);
  assign credit = (in_use < CNT_W'(MAX_OS));

  always_comb begin
    state_d = state_q;
    req_vld = 1'b0;
    unique case (state_q)
      FS_BOOT:  state_d = FS_FETCH;
      FS_FETCH: begin
        req_vld = credit && !stall_i;
        if (req_vld && !ibus_req_rdy_i) state_d = FS_HOLD;
      end
      FS_HOLD: begin
        req_vld = 1'b1;
        if (ibus_req_rdy_i) state_d = FS_FETCH;
      end
      default:  state_d = FS_BOOT;
    endcase
  end

  assign hs       = req_vld && ibus_req_rdy_i;
  assign rsp_live = ibus_rsp_vld_i && !redir && (kill_cnt_q == '0);
  // A request completing under a pending or same-cycle redirect is stale.
  assign pc_push  = hs && !merged_vld;

  always_comb begin
    os_cnt_d    = os_cnt_q + CNT_W'(hs) - CNT_W'(ibus_rsp_vld_i);
    kill_cnt_d  = kill_cnt_q - CNT_W'(ibus_rsp_vld_i && (kill_cnt_q != '0))
                + CNT_W'(hs && rbuf_vld_q);
    fetch_pc_d  = fetch_pc_q;
    rbuf_vld_d  = rbuf_vld_q;
    rbuf_pc_d   = rbuf_pc_q;
    rbuf_prio_d = rbuf_prio_q;
    if (redir) kill_cnt_d = os_cnt_d;
    if (hs) begin
      fetch_pc_d = merged_vld ? merged_pc : pc_plus4;
      rbuf_vld_d = 1'b0;
    end else if (redir && req_vld) begin
      rbuf_vld_d  = 1'b1;
      rbuf_pc_d   = merged_pc;
      rbuf_prio_d = merged_prio;
    end else if (redir) begin
      fetch_pc_d = new_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= FS_BOOT;
      fetch_pc_q  <= RST_PC;
      os_cnt_q    <= '0;
      kill_cnt_q  <= '0;
      rbuf_vld_q  <= 1'b0;
      rbuf_pc_q   <= '0;
      rbuf_prio_q <= RP_NONE;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      os_cnt_q    <= os_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
      rbuf_vld_q  <= rbuf_vld_d;
      rbuf_pc_q   <= rbuf_pc_d;
      rbuf_prio_q <= rbuf_prio_d;
    end
  end

  // Live outstanding requests are exactly those still tracked in the PC FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) assert (CNT_W'(pc_cnt) == (os_cnt_q - kill_cnt_q));
  end

  utils_adder32 u_pc_add (
    .a_i  (fetch_pc_q),
    .b_i  (32'd4),
    .sum_o(pc_plus4)
  );

  utils_fifo #(.DEPTH(MAX_OS), .WIDTH(32)) u_pc_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (redir),
    .push_i     (pc_push),
    .push_data_i(fetch_pc_q),
    .pop_i      (rsp_live),
    .pop_data_o (pc_head),
    .count_o    (pc_cnt)
  );

  utils_fifo #(.DEPTH(MAX_OS), .WIDTH(64)) u_ibuf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (redir),
    .push_i     (rsp_live),
    .push_data_i({ibus_rsp_data_i, pc_head}),
    .pop_i      (inst_pop),
    .pop_data_o (ibuf_head),
    .count_o    (ibuf_cnt)
  );

  assign inst_vld_o         = (ibuf_cnt != '0);
  assign inst_pop           = inst_vld_o && if_rdy_i;
  assign {inst_o, inst_pc_o} = ibuf_head;
  assign ibus_req_vld_o     = req_vld;
  assign ibus_req_addr_o    = fetch_pc_q;

endmodule

// File: tb/tb_k423_if_fetch_ctrl.sv
// Directed bench for k423_if_fetch_ctrl with an in-order 1-cycle bus model
// and scoreboards for issued addresses and delivered instructions.
module tb_k423_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_redir_i, bju_redir_i, bpu_redir_i, stall_i;
  logic [31:0] trap_pc_i, bju_pc_i, bpu_pc_i;
  logic        ibus_req_vld_o, ibus_req_rdy_i;
  logic [31:0] ibus_req_addr_o;
  logic        ibus_rsp_vld_i;
  logic [31:0] ibus_rsp_data_i;
  logic        inst_vld_o, if_rdy_i;
  logic [31:0] inst_o, inst_pc_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] bus_q[$];
  logic        rsp_en = 1'b1;

  always #5 clk = ~clk;

  k423_if_fetch_ctrl #(.RST_PC(32'h8000_0000), .MAX_OS(2)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .trap_redir_i   (trap_redir_i),
    .trap_pc_i      (trap_pc_i),
    .bju_redir_i    (bju_redir_i),
    .bju_pc_i       (bju_pc_i),
    .bpu_redir_i    (bpu_redir_i),
    .bpu_pc_i       (bpu_pc_i),
    .stall_i        (stall_i),
    .ibus_req_vld_o (ibus_req_vld_o),
    .ibus_req_addr_o(ibus_req_addr_o),
    .ibus_req_rdy_i (ibus_req_rdy_i),
    .ibus_rsp_vld_i (ibus_rsp_vld_i),
    .ibus_rsp_data_i(ibus_rsp_data_i),
    .inst_vld_o     (inst_vld_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .if_rdy_i       (if_rdy_i)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus model: in-order, answers each accepted request one cycle later.
  initial begin
    logic        hs_s, rsp_s;
    logic [31:0] a_s;
    ibus_rsp_vld_i  = 1'b0;
    ibus_rsp_data_i = '0;
    forever begin
      @(negedge clk);
      hs_s  = ibus_req_vld_o && ibus_req_rdy_i;
      a_s   = ibus_req_addr_o;
      rsp_s = ibus_rsp_vld_i;
      @(posedge clk);
      #2;
      if (rsp_s && bus_q.size() != 0) void'(bus_q.pop_front());
      if (hs_s) begin
        bus_q.push_back(a_s);
        checks++;
        assert (exp_addr_q.size() != 0) else begin
          errors++;
          $error("FAIL req_unexpected: observed %h expected none", a_s);
        end
        if (exp_addr_q.size() != 0) chk("req_addr", a_s, exp_addr_q.pop_front());
      end
      ibus_rsp_vld_i  = rsp_en && (bus_q.size() != 0);
      ibus_rsp_data_i = '0;
      if (ibus_rsp_vld_i) ibus_rsp_data_i = mem_data(bus_q[0]);
    end
  end

  // Instruction monitor: every consumed instruction is checked in order.
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (rst_n && inst_vld_o && if_rdy_i) begin
        checks++;
        assert (exp_pc_q.size() != 0) else begin
          errors++;
          $error("FAIL inst_unexpected: observed pc %h expected none", inst_pc_o);
        end
        if (exp_pc_q.size() != 0) begin
          p = exp_pc_q.pop_front();
          chk("inst_pc", inst_pc_o, p);
          chk("inst_data", inst_o, mem_data(p));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_n(input int n);
    int cnt = 0;
    ibus_req_rdy_i = 1'b1;
    for (int t = 0; t < 200 && cnt < n; t++) begin
      @(negedge clk);
      if (ibus_req_vld_o) cnt++;
      cyc();
    end
    ibus_req_rdy_i = 1'b0;
    chk("issue_count", 32'(cnt), 32'(n));
  endtask

  task automatic wait_vld();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ibus_req_vld_o) break;
    end
    chk("wait_vld", 32'(ibus_req_vld_o), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_pc_q.size() != 0; t++) cyc();
    repeat (3) cyc();
    chk("drain", 32'(exp_pc_q.size()), 32'd0);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic live);
    exp_addr_q.push_back(a);
    if (live) exp_pc_q.push_back(a);
  endtask

  initial begin
    rst_n = 1'b0;
    trap_redir_i = 1'b0; bju_redir_i = 1'b0; bpu_redir_i = 1'b0;
    trap_pc_i = '0; bju_pc_i = '0; bpu_pc_i = '0;
    stall_i = 1'b0; ibus_req_rdy_i = 1'b0; if_rdy_i = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_vld", 32'(ibus_req_vld_o), 32'd0);
    chk("rst_inst_vld", 32'(inst_vld_o), 32'd0);
    chk("rst_req_addr", ibus_req_addr_o, 32'h8000_0000);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req_vld", 32'(ibus_req_vld_o), 32'd0);
    cyc();

    // Sequential fetch, then a held request on 8000_0004.
    push_exp(32'h8000_0000, 1'b1);
    issue_n(1);
    wait_vld();
    for (int i = 0; i < 3; i++) begin
      chk("hold_vld", 32'(ibus_req_vld_o), 32'd1);
      chk("hold_addr", ibus_req_addr_o, 32'h8000_0004);
      @(negedge clk);
    end
    cyc();
    for (int i = 1; i < 4; i++) push_exp(32'h8000_0000 + 32'(4 * i), 1'b1);
    issue_n(3);
    drain();

    // Two outstanding, then a branch mispredict kills both.
    rsp_en = 1'b0;
    push_exp(32'h8000_0010, 1'b0);
    push_exp(32'h8000_0014, 1'b0);
    issue_n(2);
    @(negedge clk);
    chk("no_credit_vld", 32'(ibus_req_vld_o), 32'd0);
    cyc();
    bju_redir_i = 1'b1; bju_pc_i = 32'h8000_0100;
    cyc();
    bju_redir_i = 1'b0;
    @(negedge clk);
    chk("bju_addr", ibus_req_addr_o, 32'h8000_0100);
    chk("bju_inst_vld", 32'(inst_vld_o), 32'd0);
    cyc();
    rsp_en = 1'b1;
    push_exp(32'h8000_0100, 1'b1);
    issue_n(1);
    drain();

    // Trap and bju together while held, then a weaker bpu: trap must win.
    wait_vld();
    cyc();
    trap_redir_i = 1'b1; trap_pc_i = 32'h8000_0200;
    bju_redir_i  = 1'b1; bju_pc_i  = 32'h8000_0100;
    cyc();
    trap_redir_i = 1'b0; bju_redir_i = 1'b0;
    bpu_redir_i  = 1'b1; bpu_pc_i  = 32'h8000_0300;
    cyc();
    bpu_redir_i = 1'b0;
    @(negedge clk);
    chk("redir_hold_vld", 32'(ibus_req_vld_o), 32'd1);
    chk("redir_hold_addr", ibus_req_addr_o, 32'h8000_0104);
    cyc();
    push_exp(32'h8000_0104, 1'b0);
    push_exp(32'h8000_0200, 1'b1);
    issue_n(2);
    drain();

    // IF stage back-pressure exhausts credit until one instruction is taken.
    if_rdy_i = 1'b0;
    push_exp(32'h8000_0204, 1'b1);
    push_exp(32'h8000_0208, 1'b1);
    issue_n(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_buf_vld", 32'(ibus_req_vld_o), 32'd0);
    end
    chk("full_buf_inst_vld", 32'(inst_vld_o), 32'd1);
    chk("full_buf_inst_pc", inst_pc_o, 32'h8000_0204);
    cyc();
    if_rdy_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (ibus_req_vld_o) break;
    end
    chk("vld_after_pop", 32'(ibus_req_vld_o), 32'd1);
    cyc();
    drain();

    // Trap to the top of the address space; sequential fetch wraps to 0.
    trap_redir_i = 1'b1; trap_pc_i = 32'hFFFF_FFFC;
    cyc();
    trap_redir_i = 1'b0;
    push_exp(32'h8000_020C, 1'b0);
    push_exp(32'hFFFF_FFFC, 1'b1);
    push_exp(32'h0000_0000, 1'b1);
    issue_n(3);
    drain();

    // Stall leaves a held request alone but blocks new issue.
    wait_vld();
    cyc();
    stall_i = 1'b1;
    @(negedge clk);
    chk("stall_hold_vld", 32'(ibus_req_vld_o), 32'd1);
    cyc();
    push_exp(32'h0000_0004, 1'b1);
    issue_n(1);
    ibus_req_rdy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_block_vld", 32'(ibus_req_vld_o), 32'd0);
    end
    cyc();
    ibus_req_rdy_i = 1'b0;
    stall_i = 1'b0;
    push_exp(32'h0000_0008, 1'b1);
    issue_n(1);
    drain();

    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
